life_cell_gen: RTL

//  Game-of-life cell engine with a configurable rule and a 2-stage valid/ready pipeline.

---
 rtl/life_cell_gen_pkg.sv | 12 +
 rtl/life_popcount.sv | 17 +
 rtl/life_cell_gen.sv | 98 +++++++++
 3 files changed

// File: rtl/life_cell_gen_pkg.sv
// rtl/life_cell_gen_pkg.sv - shared rule constants and parameter checks for the life cell engine
package life_cell_gen_pkg;

    localparam logic [8:0] LIFE_B_CONWAY = 9'b000001000;
    localparam logic [8:0] LIFE_S_CONWAY = 9'b000001100;

    // The count must hold N_IN itself, so 2**CNT_W has to exceed N_IN.
    function automatic bit cnt_w_ok(input int n_in, input int cnt_w);
        return (n_in >= 2) && ((1 << cnt_w) > n_in);
    endfunction

endpackage

// File: rtl/life_popcount.sv
// rtl/life_popcount.sv - combinational population count of the neighbour bits
module life_popcount #(
    parameter int N_IN  = 8,
    parameter int CNT_W = 4
) (
    input  logic [N_IN-1:0]  nbr,
    output logic [CNT_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N_IN; i++) begin
            cnt = cnt + CNT_W'(nbr[i]);
        end
    end

endmodule

// File: rtl/life_cell_gen.sv
// rtl/life_cell_gen.sv - game-of-life cell with programmable rule and 2-stage valid/ready pipeline
module life_cell_gen
    import life_cell_gen_pkg::*;
#(
    parameter int              N_IN  = 8,
    parameter int              CNT_W = 4,
    parameter int              GEN_W = 16,
    parameter logic [N_IN:0]   B_RST = (N_IN+1)'(LIFE_B_CONWAY),
    parameter logic [N_IN:0]   S_RST = (N_IN+1)'(LIFE_S_CONWAY)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [N_IN:0]     cfg_birth,
    input  logic [N_IN:0]     cfg_surv,
    input  logic              load,
    input  logic              load_alive,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   nbr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              alive,
    output logic [CNT_W-1:0]  count,
    output logic [GEN_W-1:0]  gen
);

    if (!cnt_w_ok(N_IN, CNT_W)) begin : g_bad_cnt_w
        $error("life_cell_gen: CNT_W too narrow for N_IN");
    end

    logic [N_IN:0]     birth_q;
    logic [N_IN:0]     surv_q;
    logic              s1_valid;
    logic [CNT_W-1:0]  s1_cnt;
    logic [CNT_W-1:0]  pop_cnt;
    logic              adv2;
    logic              accept;
    logic              nxt_alive;

    life_popcount #(
        .N_IN  (N_IN),
        .CNT_W (CNT_W)
    ) u_popcount (
        .nbr (nbr),
        .cnt (pop_cnt)
    );

    assign adv2      = !out_valid || out_ready;
    assign in_ready  = !load && (!s1_valid || adv2);
    assign accept    = in_valid && in_ready;
    assign nxt_alive = alive ? surv_q[s1_cnt] : birth_q[s1_cnt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            birth_q <= B_RST;
            surv_q  <= S_RST;
        end else if (cfg_we) begin
            birth_q <= cfg_birth;
            surv_q  <= cfg_surv;
        end
    end

    // load wins over both stages; masks still update via the block above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_cnt    <= '0;
            out_valid <= 1'b0;
            alive     <= 1'b0;
            count     <= '0;
            gen       <= '0;
        end else if (load) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            alive     <= load_alive;
            count     <= '0;
            gen       <= '0;
        end else begin
            if (accept) begin
                s1_cnt   <= pop_cnt;
                s1_valid <= 1'b1;
            end else if (adv2) begin
                s1_valid <= 1'b0;
            end

            if (s1_valid && adv2) begin
                alive     <= nxt_alive;
                count     <= s1_cnt;
                gen       <= gen + 1'b1;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
